// File: rtl/popcount18_neuron_acc.sv
// Ternary-neuron back end: accumulates (pos - neg) popcount deltas per vector and thresholds the sum.
// Optional NEURON_SAT_EN: saturating accumulator add (default build wraps modulo 2^ACC_W).
module popcount18_neuron_acc #(
  parameter int ACC_W     = 10,
  parameter int THRESH    = 0,
  parameter int MAX_BEATS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_pos,
  input  logic [4:0]       in_neg,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_act,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_beats,
  output logic             out_ovf
);

  // state  | meaning
  // IDLE   | acc 0, beat count 0, overflow clear
  // ACCUM  | at least one beat taken, vector open
  // HOLD   | result registered and presented
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic signed [ACC_W-1:0] THRESH_C = ACC_W'(THRESH);
  localparam logic [7:0]              MAX_B    = 8'(MAX_BEATS);

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       beats_q, beats_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_act_q, out_act_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [7:0]       out_beats_q, out_beats_d;
  logic             out_ovf_q, out_ovf_d;

  logic [5:0]       delta;
  logic [ACC_W-1:0] delta_ext;
  logic [ACC_W:0]   sum_wide;
  logic             ovf_hit;
  logic [ACC_W-1:0] acc_new;
  logic [7:0]       beats_inc;
  logic             accept;
  logic             close;

  always_comb begin
    // 6-bit modular subtraction yields the correct two's complement delta in -31..31
    delta     = {1'b0, in_pos} - {1'b0, in_neg};
    delta_ext = {{(ACC_W-6){delta[5]}}, delta};
    sum_wide  = {acc_q[ACC_W-1], acc_q} + {delta_ext[ACC_W-1], delta_ext};
    ovf_hit   = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
`ifdef NEURON_SAT_EN
    if (ovf_hit) acc_new = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else         acc_new = sum_wide[ACC_W-1:0];
`else
    acc_new = sum_wide[ACC_W-1:0];
`endif
    beats_inc = beats_q + 8'd1;
    accept    = in_valid & in_ready_q;
    close     = in_last | (beats_inc == MAX_B);
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beats_d     = beats_q;
    ovf_d       = ovf_q;
    out_act_d   = out_act_q;
    out_sum_d   = out_sum_q;
    out_beats_d = out_beats_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) begin
          if (close) begin
            out_sum_d   = acc_new;
            out_act_d   = ($signed(acc_new) >= THRESH_C);
            out_beats_d = beats_inc;
            out_ovf_d   = ovf_q | ovf_hit;
            // running state is cleared now; the result lives in the out_* registers
            acc_d       = '0;
            beats_d     = '0;
            ovf_d       = 1'b0;
            state_d     = S_HOLD;
          end else begin
            acc_d   = acc_new;
            beats_d = beats_inc;
            ovf_d   = ovf_q | ovf_hit;
            state_d = S_ACCUM;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          beats_d = '0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d != S_HOLD);
    out_valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      beats_q     <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_act_q   <= 1'b0;
      out_sum_q   <= '0;
      out_beats_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beats_q     <= beats_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_act_q   <= out_act_d;
      out_sum_q   <= out_sum_d;
      out_beats_q <= out_beats_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_act   = out_act_q;
  assign out_sum   = out_sum_q;
  assign out_beats = out_beats_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_popcount18_neuron_acc.sv
// Scoreboard bench for popcount18_neuron_acc at ACC_W=7 so overflow behaviour is reachable.
module tb_popcount18_neuron_acc;
  localparam int ACC_W = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [4:0]       in_pos = '0;
  logic [4:0]       in_neg = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_act;
  logic [ACC_W-1:0] out_sum;
  logic [7:0]       out_beats;
  logic             out_ovf;

  typedef struct packed {
    logic signed [ACC_W-1:0] sum;
    logic                    act;
    logic [7:0]              beats;
    logic                    ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  popcount18_neuron_acc #(.ACC_W(ACC_W), .THRESH(0), .MAX_BEATS(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pos(in_pos), .in_neg(in_neg), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_act(out_act),
    .out_sum(out_sum), .out_beats(out_beats), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic push(input int sum, input bit act, input int beats, input bit ovf);
    exp_t e;
    e.sum   = ACC_W'(sum);
    e.act   = act;
    e.beats = 8'(beats);
    e.ovf   = ovf;
    exp_q.push_back(e);
  endtask

  // drives one beat, waits (bounded) for in_ready, returns just after the accepting edge
  task automatic beat(input logic [4:0] p, input logic [4:0] n, input logic l);
    int waits;
    waits = 0;
    @(negedge clk);
    in_valid = 1'b1; in_pos = p; in_neg = n; in_last = l;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL beat_accept_timeout: in_ready stuck at 0, want 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // monitor: every completed output handshake pops one expected result
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_result: sum %0d with empty scoreboard, want none", $signed(out_sum));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_sum",   int'($signed(out_sum)), int'(e.sum));
        chk("out_act",   int'(out_act),          int'(e.act));
        chk("out_beats", int'(out_beats),        int'(e.beats));
        chk("out_ovf",   int'(out_ovf),          int'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  int'(in_ready),  1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_act",   int'(out_act),   0);
    chk("rst_out_sum",   int'(out_sum),   0);
    chk("rst_out_beats", int'(out_beats), 0);
    chk("rst_out_ovf",   int'(out_ovf),   0);

    // 3-beat vector: 3 - 4 + 8 = 7
    push(7, 1'b1, 3, 1'b0);
    beat(5'd5, 5'd2, 1'b0);
    beat(5'd0, 5'd4, 1'b0);
    beat(5'd9, 5'd1, 1'b1);
    @(negedge clk);
    chk("t1_valid_hi",  int'(out_valid), 1);
    chk("t1_ready_lo",  int'(in_ready),  0);
    @(negedge clk);
    chk("t1_valid_one", int'(out_valid), 0);
    chk("t1_ready_hi",  int'(in_ready),  1);

    // single beat goes straight to HOLD
    push(-15, 1'b0, 1, 1'b0);
    beat(5'd0, 5'd15, 1'b1);
    @(negedge clk);
    chk("t2_direct_hold", int'(out_valid), 1);

    // auto-close at MAX_BEATS, then stall with a pending beat
    push(8, 1'b1, 8, 1'b0);
    for (int i = 0; i < 7; i++) beat(5'd1, 5'd0, 1'b0);
    out_ready = 1'b0;
    beat(5'd1, 5'd0, 1'b0);
    in_valid = 1'b1; in_pos = 5'd2; in_neg = 5'd0; in_last = 1'b1;
    push(2, 1'b1, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready",  int'(in_ready),  0);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_out_sum",   int'($signed(out_sum)), 8);
      chk("stall_out_beats", int'(out_beats), 8);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_ready_hi", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("beat9_closed", int'(out_valid), 1);

    // 4 x 31 overflows a 7-bit accumulator
`ifdef NEURON_SAT_EN
    push(63, 1'b1, 4, 1'b1);
`else
    push(-4, 1'b0, 4, 1'b1);
`endif
    for (int i = 0; i < 3; i++) beat(5'd31, 5'd0, 1'b0);
    beat(5'd31, 5'd0, 1'b1);

    // reset mid-vector discards partial sum
    beat(5'd1, 5'd1, 1'b0);
    beat(5'd4, 5'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready",  int'(in_ready),  1);
    chk("midrst_out_sum",   int'(out_sum),   0);
    push(3, 1'b1, 1, 1'b0);
    beat(5'd3, 5'd0, 1'b1);

    waits = 0;
    while (exp_q.size() != 0 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/popcount18_neuron_acc.md
# popcount18_neuron_acc

Sequential ternary-neuron back end that consumes the two 5-bit approximate popcounts of an 18-input slice: one count over positive-weight inputs, one over negative-weight inputs. It accumulates the signed difference over a multi-beat input vector, compares the total against a threshold, and emits one binary activation per vector. It sits directly downstream of the pair of popcount18 instances in a printed ternary neuron.

## Interface
- `ACC_W`, 10: accumulator and `out_sum` width, signed two's complement; minimum 7.
- `THRESH`, 0: signed activation threshold, ACC_W bits.
- `MAX_BEATS`, 8: beats per vector before an automatic close; range 1..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: beat present.
- `in_ready` output 1: block can accept a beat.
- `in_pos` input 5: popcount of the positive-weight slice, unsigned 0..31.
- `in_neg` input 5: popcount of the negative-weight slice, unsigned 0..31.
- `in_last` input 1: final beat of the vector.
- `out_valid` output 1: result held.
- `out_ready` input 1: consumer takes the result.
- `out_act` output 1: 1 iff `out_sum >= THRESH` (signed compare).
- `out_sum` output ACC_W: final signed accumulation.
- `out_beats` output 8: beats accumulated into this result.
- `out_ovf` output 1: overflow or clamp occurred during the vector.

## Operation
- FSM has three states:
  - IDLE: accumulator 0, beat count 0, overflow flag clear.
  - ACCUM: at least one beat taken, vector still open.
  - HOLD: result registered and presented.
- Beat accept occurs when `in_valid & in_ready`. `in_ready = 1` in IDLE and ACCUM, 0 in HOLD.
- On each accepted beat:
  - Delta is computed as `in_pos - in_neg`, 6-bit signed, range -31..31, sign-extended to ACC_W.
  - `acc <= acc + delta`.
  - `beats <= beats + 1`.
- The vector closes on an accepted beat when `in_last = 1` or `beats + 1 == MAX_BEATS`. On close:
  - `out_sum`, `out_act`, `out_beats` and `out_ovf` load from the post-add values.
  - FSM goes to HOLD.
- Otherwise IDLE→ACCUM on the first accepted beat; ACCUM stays in ACCUM.
- A single-beat vector (`in_last` on the first beat) goes IDLE→HOLD directly.
- In HOLD, `out_valid & out_ready` returns the FSM to IDLE and clears acc, beats and the overflow flag.
- `out_*` data remain stable while `out_valid = 1` and until the handshake completes.
- No accept occurs in HOLD, so no beat is lost or double-counted.
- `rst` at any point, including mid-vector or in HOLD, discards the partial vector and returns to IDLE.

## Timing
- Reset values:
  - `in_ready = 1`
  - `out_valid = 0`
  - `out_act = 0`
  - `out_sum = 0`
  - `out_beats = 0`
  - `out_ovf = 0`
- Latency: `out_valid` rises on the clock edge that accepts the closing beat and is visible the cycle after it.
- Throughput: one beat per cycle within a vector. Between vectors there is one HOLD cycle minimum, and `in_ready` is low that cycle.
- The output handshake and `in_ready` rising occur on the same edge. A new beat can be accepted on the following cycle.
- `in_ready` is a registered function of state only and has no combinational path from `out_ready`.

## Configuration
- `NEURON_SAT_EN` defined: the add saturates.
  - Results above 2^(ACC_W-1)-1 clamp to that maximum.
  - Results below -2^(ACC_W-1) clamp to that minimum.
  - Any clamp sets the sticky overflow flag.
- `NEURON_SAT_EN` undefined: the add wraps modulo 2^ACC_W. Signed overflow (operand signs equal, result sign differs) sets the sticky overflow flag.
- `out_ovf` reports the sticky flag in both modes.

## Test plan
- Reset, then a 3-beat vector (pos,neg) = (5,2), (0,4), (9,1) with `in_last` on beat 3 and `out_ready = 1`:
  - `out_sum = 7`, `out_act = 1`, `out_beats = 3`, `out_ovf = 0`.
  - `out_valid` lasts one cycle.
  - `in_ready` is low exactly one cycle.
- Single beat (0,15) with `in_last`:
  - FSM goes IDLE→HOLD.
  - `out_sum = -15`, `out_act = 0`.
- `MAX_BEATS = 8`, 8 beats of (1,0) with `in_last` never asserted:
  - Auto-close after beat 8 with `out_sum = 8` and `out_beats = 8`.
  - Beat 9 is accepted only after the output handshake.
- Hold `out_ready = 0` for 5 cycles with `in_valid` held high:
  - Outputs stay stable.
  - `in_ready = 0` and no beat is accepted.
  - After release, the next vector starts from acc 0.
- `ACC_W = 7`, 4 beats of (31,0):
  - With the macro: `out_sum = 63`, `out_ovf = 1`.
  - Without the macro: `out_sum = -4` (124 mod 128 as signed), `out_ovf = 1`.
- Assert `rst` after beat 2 of a vector, then send a fresh 1-beat vector (3,0):
  - `out_sum = 3`, `out_beats = 1`.
